serial_feed_ctrl: RTL and testbench

//  Sequencer that feeds the serial sequence detector. Captures a DATA_W-bit word from the board

---
 rtl/serial_feed_ctrl.sv | 131 +++++++++++++
 tb/tb_serial_feed_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_feed_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_feed_ctrl
// Brief    : Captures a switch word on start and shifts it out one bit per
//            paced strobe to the sequence detector, counting detector hits.
// Revision : 1.0 - initial release
// ============================================================================
module serial_feed_ctrl #(
    parameter int DATA_W    = 8,
    parameter int TICK_DIV  = 50000,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] word_i,
    input  logic              repeat_i,
    input  logic              hit_i,
    output logic              bit_o,
    output logic              bit_vld_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [3:0]        bit_idx_o,
    output logic [3:0]        hit_cnt_o
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] C_TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [3:0]        C_LAST_BIT  = 4'(DATA_W - 1);

    localparam logic [1:0] C_IDLE   = 2'd0;
    localparam logic [1:0] C_WAIT   = 2'd1;
    localparam logic [1:0] C_STROBE = 2'd2;
    localparam logic [1:0] C_DONE   = 2'd3;

    logic [1:0]        state_q,   state_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [DATA_W-1:0] shreg_q,   shreg_d;
    logic [DATA_W-1:0] word_q,    word_d;
    logic [3:0]        bit_idx_q, bit_idx_d;
    logic [3:0]        hit_cnt_q, hit_cnt_d;
    logic [DATA_W-1:0] w_shifted;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shifted = {shreg_q[DATA_W-2:0], 1'b0};
            assign bit_o     = shreg_q[DATA_W-1];
        end else begin : g_lsb_first
            assign w_shifted = {1'b0, shreg_q[DATA_W-1:1]};
            assign bit_o     = shreg_q[0];
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        shreg_d    = shreg_q;
        word_d     = word_q;
        bit_idx_d  = bit_idx_q;
        hit_cnt_d  = hit_cnt_q;

        // Hits are credited first so a DONE-cycle hit lands on the finished word.
        if ((state_q != C_IDLE) && hit_i && (hit_cnt_q != 4'hF)) begin
            hit_cnt_d = hit_cnt_q + 4'd1;
        end

        case (state_q)
            C_IDLE: begin
                if (start_i) begin
                    shreg_d    = word_i;
                    word_d     = word_i;
                    tick_cnt_d = '0;
                    bit_idx_d  = 4'd0;
                    hit_cnt_d  = 4'd0;
                    state_d    = C_WAIT;
                end
            end
            C_WAIT: begin
                if (tick_cnt_q == C_TICK_LAST) begin
                    tick_cnt_d = '0;
                    state_d    = C_STROBE;
                end else begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                end
            end
            C_STROBE: begin
                shreg_d   = w_shifted;
                bit_idx_d = bit_idx_q + 4'd1;
                state_d   = (bit_idx_q == C_LAST_BIT) ? C_DONE : C_WAIT;
            end
            C_DONE: begin
                if (repeat_i) begin
                    shreg_d    = word_q;
                    tick_cnt_d = '0;
                    bit_idx_d  = 4'd0;
                    hit_cnt_d  = 4'd0;
                    state_d    = C_WAIT;
                end else begin
                    state_d = C_IDLE;
                end
            end
            default: state_d = C_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= C_IDLE;
            tick_cnt_q <= '0;
            shreg_q    <= '0;
            word_q     <= '0;
            bit_idx_q  <= 4'd0;
            hit_cnt_q  <= 4'd0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            shreg_q    <= shreg_d;
            word_q     <= word_d;
            bit_idx_q  <= bit_idx_d;
            hit_cnt_q  <= hit_cnt_d;
        end
    end

    assign bit_vld_o = (state_q == C_STROBE);
    assign busy_o    = (state_q != C_IDLE);
    assign done_o    = (state_q == C_DONE);
    assign bit_idx_o = bit_idx_q;
    assign hit_cnt_o = hit_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_feed_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_feed_ctrl
// Brief    : Self-checking bench for serial_feed_ctrl (MSB- and LSB-first).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_feed_ctrl;

    localparam int D    = 8;
    localparam int TD   = 4;
    localparam int P    = TD + 1;
    localparam int LAST = D * P + 1;

    logic       clk = 1'b0;
    logic       rst, start, rpt, hit;
    logic [7:0] word;

    wire       a_bit, a_vld, a_busy, a_done;
    wire [3:0] a_idx, a_hits;
    wire       b_bit, b_vld, b_busy, b_done;
    wire [3:0] b_idx, b_hits;

    serial_feed_ctrl #(.DATA_W(D), .TICK_DIV(TD), .MSB_FIRST(1'b1)) dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start), .word_i(word),
        .repeat_i(rpt), .hit_i(hit), .bit_o(a_bit), .bit_vld_o(a_vld),
        .busy_o(a_busy), .done_o(a_done), .bit_idx_o(a_idx), .hit_cnt_o(a_hits)
    );

    serial_feed_ctrl #(.DATA_W(D), .TICK_DIV(TD), .MSB_FIRST(1'b0)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start), .word_i(word),
        .repeat_i(rpt), .hit_i(hit), .bit_o(b_bit), .bit_vld_o(b_vld),
        .busy_o(b_busy), .done_o(b_done), .bit_idx_o(b_idx), .hit_cnt_o(b_hits)
    );

    always #5 clk = ~clk;

    // Model: a word in flight is described by its cycle offset since acceptance.
    typedef struct {
        bit         busy;
        int         rel;
        logic [7:0] word;
        int         hits;
        int         idx;
    } model_t;

    model_t m_a, m_b;
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t0       = 0;
    int a_strobe_rel[$];
    int a_done_rel[$];
    logic [15:0] a_seq, b_seq;

    function automatic model_t m_step(model_t m, logic r, logic s, logic rp,
                                      logic h, logic [7:0] w);
        model_t n = m;
        if (r) begin
            n.busy = 1'b0; n.rel = 0; n.word = '0; n.hits = 0; n.idx = 0;
        end else if (!m.busy) begin
            if (s) begin
                n.busy = 1'b1; n.rel = 1; n.word = w; n.hits = 0;
            end
        end else begin
            if (h && n.hits < 15) n.hits = n.hits + 1;
            if (m.rel == LAST) begin
                if (rp) begin
                    n.rel = 1; n.hits = 0;
                end else begin
                    n.busy = 1'b0; n.idx = D;
                end
            end else begin
                n.rel = m.rel + 1;
            end
        end
        return n;
    endfunction

    // Packed as {bit, vld, busy, done, idx[3:0], hits[3:0]}.
    function automatic logic [11:0] m_out(model_t m, bit msb);
        int   idx;
        logic bv, vld, dn;
        logic [7:0] w;
        w   = m.word;
        idx = m.busy ? (m.rel - 1) / P : m.idx;
        vld = m.busy && (m.rel % P == 0) && (m.rel <= D * P);
        dn  = m.busy && (m.rel == LAST);
        bv  = (idx < D) ? (msb ? w[D-1-idx] : w[idx]) : 1'b0;
        return {bv, vld, m.busy, dn, 4'(idx), 4'(m.hits)};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        m_a = m_step(m_a, rst, start, rpt, hit, word);
        m_b = m_step(m_b, rst, start, rpt, hit, word);
        cyc++;
    end

    always @(posedge clk) begin
        logic [11:0] exp_a, exp_b, act_a, act_b;
        #1;
        exp_a = m_out(m_a, 1'b1);
        exp_b = m_out(m_b, 1'b0);
        act_a = {a_bit, a_vld, a_busy, a_done, a_idx, a_hits};
        act_b = {b_bit, b_vld, b_busy, b_done, b_idx, b_hits};
        n_checks += 2;
        if (act_a !== exp_a) begin
            n_fail++;
            $display("FAIL outputs_msb cyc=%0d got %h expected %h", cyc, act_a, exp_a);
        end
        if (act_b !== exp_b) begin
            n_fail++;
            $display("FAIL outputs_lsb cyc=%0d got %h expected %h", cyc, act_b, exp_b);
        end
        if (a_vld === 1'b1) begin
            a_strobe_rel.push_back(cyc - t0);
            a_seq = {a_seq[14:0], a_bit};
        end
        if (b_vld === 1'b1) b_seq = {b_seq[14:0], b_bit};
        if (a_done === 1'b1) a_done_rel.push_back(cyc - t0);
    end

    task automatic wait_rel(input int n);
        while (cyc < t0 + n) @(negedge clk);
    endtask

    task automatic start_word(input logic [7:0] w);
        a_strobe_rel.delete();
        a_done_rel.delete();
        a_seq = '0;
        b_seq = '0;
        start = 1'b1;
        word  = w;
        t0    = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_hit(input int n);
        wait_rel(n);
        hit = 1'b1;
        @(negedge clk);
        hit = 1'b0;
    endtask

    function automatic int q_at(input int k);
        return (a_strobe_rel.size() > k) ? a_strobe_rel[k] : -1;
    endfunction

    function automatic int d_at(input int k);
        return (a_done_rel.size() > k) ? a_done_rel[k] : -1;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; rpt = 1'b0; hit = 1'b0; word = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_outputs", int'({a_bit, a_vld, a_busy, a_done, a_idx, a_hits}), 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic word, ignored mid-word start, hits incl. DONE cycle.
        start_word(8'hB6);
        wait_rel(12);
        start = 1'b1; word = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        pulse_hit(22);
        pulse_hit(37);
        pulse_hit(41);
        pulse_hit(46);
        wait_rel(48);
        check("t1_strobe_count", a_strobe_rel.size(), 8);
        for (int k = 0; k < 8; k++) check("t1_strobe_cycle", q_at(k), 5 * (k + 1));
        check("t1_bits_msb", int'(a_seq[7:0]), 8'hB6);
        check("t2_bits_lsb", int'(b_seq[7:0]), 8'h6D);
        check("t1_done_cycle", d_at(0), 41);
        check("t1_idle_idx", int'(a_idx), 8);
        check("t4_hits_after_idle_hit", int'(a_hits), 3);
        check("t1_idle_busy", int'(a_busy), 0);

        // Repeat, then drop repeat mid second word.
        rpt = 1'b1;
        start_word(8'h5A);
        word = 8'h00;
        pulse_hit(10);
        pulse_hit(20);
        wait_rel(41);
        check("t5_done_hits", int'(a_hits), 2);
        check("t5_done_pulse", int'(a_done), 1);
        wait_rel(42);
        check("t5_hits_cleared", int'(a_hits), 0);
        check("t5_busy_on_repeat", int'(a_busy), 1);
        wait_rel(50);
        rpt = 1'b0;
        wait_rel(84);
        check("t5_strobe_count", a_strobe_rel.size(), 16);
        check("t5_second_first_strobe", q_at(8), 46);
        check("t5_second_done", d_at(1), 82);
        check("t5_bits", int'(a_seq), 16'h5A5A);
        check("t5_stopped", int'(a_busy), 0);

        // Reset mid-word, then a fresh word.
        start_word(8'hC3);
        wait_rel(17);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_outputs_a", int'({a_bit, a_vld, a_busy, a_done, a_idx, a_hits}), 0);
        check("t6_outputs_b", int'({b_bit, b_vld, b_busy, b_done, b_idx, b_hits}), 0);
        wait_rel(45);
        check("t6_no_more_strobes", a_strobe_rel.size(), 3);
        start_word(8'h96);
        wait_rel(44);
        check("t6_new_bits_msb", int'(a_seq[7:0]), 8'h96);
        check("t6_new_bits_lsb", int'(b_seq[7:0]), 8'h69);

        // Hit counter saturation.
        start_word(8'hFF);
        wait_rel(1);
        hit = 1'b1;
        wait_rel(21);
        hit = 1'b0;
        wait_rel(25);
        check("sat_hits_mid", int'(a_hits), 15);
        wait_rel(45);
        check("sat_hits_idle", int'(a_hits), 15);
        check("sat_idle_busy", int'(a_busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
